mem_miss_ctrl: RTL and testbench

Miss-handling sequencer between the data cache and the word-fetch/write-back data memory. Accepts one miss request at a time from the cache. If the victim line is dirty, it performs a single write-back first. It then fetches the fill word, waiting a programmable latency at each memory access, and returns the fill word to the cache in a one-cycle response.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_lat_cnt.sv | 30 +++
 rtl/mem_miss_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_miss_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the miss-handling sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } miss_state_t;

  // Memory-mapped trigger word; a fill from here returns {31'b0, trigger}.
  localparam logic [31:0] MMIO_TRIGGER_ADDR = 32'h000000FC;

  // Width of the shared access-latency counter (covers latencies 1..15).
  localparam int LAT_CNT_W = 4;

  // Byte address to word address: clear the byte-offset bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter with a zero flag, used to time each memory access.
module mem_lat_cnt
  import mem_pkg::*;
#(
  parameter int CNT_W = LAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_miss_ctrl.sv
// Miss-handling sequencer: optional single write-back of the dirty victim,
// then one word fetch, then a one-cycle fill response to the cache.
// Optional build macro MEM_MISS_STATS_EN adds saturating stat_miss/stat_wb
// counters; without it the core is complete and those ports do not exist.
module mem_miss_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_dirty,
  input  logic [DATA_WIDTH-1:0] req_fill_addr,
  input  logic [DATA_WIDTH-1:0] req_wb_addr,
  input  logic [DATA_WIDTH-1:0] req_wb_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_fetch,
  output logic                  mem_writeback,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WB_addr,
  output logic [DATA_WIDTH-1:0] mem_WB_DATA,
  input  logic [DATA_WIDTH-1:0] mem_RD,
  output logic                  busy
`ifdef MEM_MISS_STATS_EN
  ,
  output logic [31:0]           stat_miss,
  output logic [31:0]           stat_wb
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  miss_state_t           state;
  logic                  hs;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic [DATA_WIDTH-1:0] fill_al;
  logic [DATA_WIDTH-1:0] wb_al;
  logic [DATA_WIDTH-1:0] fill_addr_q;

  assign hs      = req_valid && req_ready;
  assign fill_al = word_align(req_fill_addr);
  assign wb_al   = word_align(req_wb_addr);

  // Counter is reloaded when entering WB or FILL and counts down inside them.
  assign cnt_load = ((state == IDLE) && hs) || ((state == WB) && cnt_zero);
  assign cnt_dec  = (state == WB) || (state == FILL);

  mem_lat_cnt #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Fill address held for the FILL phase that follows a write-back.
  always_ff @(posedge clk) begin
    if (hs) begin
      fill_addr_q <= fill_al;
    end
  end

  // Sequencer with registered outputs; each output reflects the state entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_fetch     <= 1'b0;
      mem_writeback <= 1'b0;
      mem_A         <= '0;
      mem_WB_addr   <= '0;
      mem_WB_DATA   <= '0;
    end else begin
      mem_writeback <= 1'b0;
      resp_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_dirty) begin
              state         <= WB;
              mem_writeback <= 1'b1;
              mem_WB_addr   <= wb_al;
              mem_WB_DATA   <= req_wb_data;
            end else begin
              state     <= FILL;
              mem_fetch <= 1'b1;
              mem_A     <= fill_al;
            end
          end
        end
        WB: begin
          if (cnt_zero) begin
            state       <= FILL;
            mem_WB_addr <= '0;
            mem_WB_DATA <= '0;
            mem_fetch   <= 1'b1;
            mem_A       <= fill_addr_q;
          end
        end
        FILL: begin
          if (cnt_zero) begin
            state      <= RESP;
            mem_fetch  <= 1'b0;
            mem_A      <= '0;
            resp_valid <= 1'b1;
            resp_data  <= mem_RD;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_MISS_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters: accepted requests and write-back pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_miss <= '0;
      stat_wb   <= '0;
    end else begin
      if (hs) begin
        stat_miss <= sat_inc(stat_miss);
      end
      if (mem_writeback) begin
        stat_wb <= sat_inc(stat_wb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_miss_ctrl.sv
// Scoreboard bench for mem_miss_ctrl with a word-addressed memory model.
module tb_mem_miss_ctrl;
  import mem_pkg::*;

  localparam int L = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_dirty;
  logic [31:0] req_fill_addr;
  logic [31:0] req_wb_addr;
  logic [31:0] req_wb_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_fetch;
  logic        mem_writeback;
  logic [31:0] mem_A;
  logic [31:0] mem_WB_addr;
  logic [31:0] mem_WB_DATA;
  logic [31:0] mem_RD;
  logic        busy;
`ifdef MEM_MISS_STATS_EN
  logic [31:0] stat_miss;
  logic [31:0] stat_wb;
`endif

  mem_miss_ctrl #(
    .DATA_WIDTH  (32),
    .MEM_LATENCY (L)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dirty     (req_dirty),
    .req_fill_addr (req_fill_addr),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .mem_fetch     (mem_fetch),
    .mem_writeback (mem_writeback),
    .mem_A         (mem_A),
    .mem_WB_addr   (mem_WB_addr),
    .mem_WB_DATA   (mem_WB_DATA),
    .mem_RD        (mem_RD),
    .busy          (busy)
`ifdef MEM_MISS_STATS_EN
    ,
    .stat_miss     (stat_miss),
    .stat_wb       (stat_wb)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic [31:0] fill;
    logic [31:0] wba;
    logic [31:0] wbd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        trigger;
  int          cyc;
  int          n_cmp;
  int          n_err;
  int          wb_pulses;
  int          fetch_cyc;
  int          hs_cnt;
  int          n_acc;
  int          n_wb_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Combinational read port with the MMIO trigger word at its fixed address.
  always_comb begin
    mem_RD = mem[widx(mem_A)];
    if (mem_A == MMIO_TRIGGER_ADDR) mem_RD = {31'b0, trigger};
  end

  always @(posedge clk) begin
    if (mem_writeback) mem[widx(mem_WB_addr)] <= mem_WB_DATA;
    if (req_valid && req_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each response, checks bus values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          chk("resp_data", resp_data, sbq[0].data);
          chk("resp_cycle", 32'(cyc), 32'(sbq[0].cyc));
          void'(sbq.pop_front());
        end
      end
      if (mem_fetch) begin
        fetch_cyc++;
        if (sbq.size() != 0) chk("mem_A", mem_A, sbq[0].fill);
      end else begin
        chk("mem_A_idle", mem_A, 32'd0);
      end
      if (mem_fetch || !busy) chk("wb_addr_idle", mem_WB_addr, 32'd0);
      if (mem_writeback) begin
        wb_pulses++;
        if (sbq.size() != 0) begin
          chk("wb_addr", mem_WB_addr, sbq[0].wba);
          chk("wb_data", mem_WB_DATA, sbq[0].wbd);
        end
      end
    end
  end

  // Model the request at the cycle it is accepted and queue its expectation.
  task automatic push_exp(input logic d, input logic [31:0] fa, input logic [31:0] wa,
                          input logic [31:0] wd);
    exp_t e;
    if (d) ref_mem[widx(wa)] = wd;
    e.fill = word_align(fa);
    e.wba  = word_align(wa);
    e.wbd  = wd;
    e.data = (e.fill == MMIO_TRIGGER_ADDR) ? {31'b0, trigger} : ref_mem[widx(fa)];
    e.cyc  = cyc + (d ? 2 * L : L) + 1;
    sbq.push_back(e);
    n_acc++;
    if (d) n_wb_acc++;
  endtask

  task automatic send(input logic d, input logic [31:0] fa, input logic [31:0] wa,
                      input logic [31:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    req_dirty = d; req_fill_addr = fa; req_wb_addr = wa; req_wb_data = wd;
    req_valid = 1'b1;
    while (!req_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    push_exp(d, fa, wa, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int w0, f0, h0, t, t1, t2;
    n_cmp = 0; n_err = 0; wb_pulses = 0; fetch_cyc = 0; hs_cnt = 0; cyc = 0;
    n_acc = 0; n_wb_acc = 0;
    trigger = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[widx(32'h0001_0000)] = 32'hDEAD_BEEF; ref_mem[widx(32'h0001_0000)] = 32'hDEAD_BEEF;
    mem[widx(32'h0001_0030)] = 32'h55AA_0000; ref_mem[widx(32'h0001_0030)] = 32'h55AA_0000;
    rst_n = 1'b0; req_valid = 1'b0; req_dirty = 1'b0;
    req_fill_addr = '0; req_wb_addr = '0; req_wb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_fetch", 32'(mem_fetch), 32'd0);
    chk("rst_wb", 32'(mem_writeback), 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    rst_n = 1'b1;

    // Clean miss with unaligned fill address.
    w0 = wb_pulses; f0 = fetch_cyc;
    send(1'b0, 32'h0001_0003, 32'h0, 32'h0);
    drain();
    chk("clean_no_wb", 32'(wb_pulses - w0), 32'd0);
    chk("clean_fill_len", 32'(fetch_cyc - f0), 32'(L));

    // Dirty miss: one write-back, then fill from a different word.
    w0 = wb_pulses; f0 = fetch_cyc;
    send(1'b1, 32'h0001_0020, 32'h0001_0010, 32'h1234_5678);
    drain();
    chk("dirty_wb_pulses", 32'(wb_pulses - w0), 32'd1);
    chk("dirty_fill_len", 32'(fetch_cyc - f0), 32'(L));
    chk("dirty_mem_written", mem[widx(32'h0001_0010)], 32'h1234_5678);

    // Same-address dirty miss returns the data just written.
    send(1'b1, 32'h0001_0040, 32'h0001_0040, 32'hA5A5_A5A5);
    drain();
    chk("same_addr_mem", mem[widx(32'h0001_0040)], 32'hA5A5_A5A5);

    // req_valid held high across a whole transaction.
    @(negedge clk);
    h0 = hs_cnt;
    req_dirty = 1'b0; req_fill_addr = 32'h0001_0000; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 64) begin @(negedge clk); t++; end
    t1 = cyc;
    push_exp(1'b0, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 64) begin @(negedge clk); t++; end
    t2 = cyc;
    chk("b2b_next_accept", 32'(t2), 32'(t1 + L + 2));
    push_exp(1'b0, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk("held_handshakes", 32'(hs_cnt - h0), 32'd2);

    // Reset pulled low during the first write-back cycle drops the write.
    @(negedge clk);
    req_dirty = 1'b1; req_fill_addr = 32'h0001_0000;
    req_wb_addr = 32'h0001_0030; req_wb_data = 32'h0BAD_0BAD; req_valid = 1'b1;
    chk("rstwb_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rstwb_first_pulse", 32'(mem_writeback), 32'd1);
    chk("rstwb_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwb_wb_clear", 32'(mem_writeback), 32'd0);
    chk("rstwb_ready", 32'(req_ready), 32'd1);
    chk("rstwb_busy_clear", 32'(busy), 32'd0);
    chk("rstwb_addr_clear", mem_WB_addr, 32'd0);
    chk("rstwb_data_clear", mem_WB_DATA, 32'd0);
    n_acc = 0; n_wb_acc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstwb_mem_unchanged", mem[widx(32'h0001_0030)], ref_mem[widx(32'h0001_0030)]);

    // MMIO trigger fill right after reset, then a normal clean request.
    trigger = 1'b1;
    send(1'b0, MMIO_TRIGGER_ADDR, 32'h0, 32'h0);
    drain();
`ifdef MEM_MISS_STATS_EN
    chk("stat_miss", stat_miss, 32'(n_acc));
    chk("stat_wb", stat_wb, 32'(n_wb_acc));
`endif
    send(1'b0, 32'h0001_0000, 32'h0, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
